tft_spi_byte_receiver: RTL
==========================

// Module: tft_spi_byte_receiver
// PURPOSE
// SPI mode-0 slave receiver. It is the far end of the TFT command link: it deserialises the cs/tft_clk/mosi
// stream that the TFT SPI pattern generator drives and presents whole bytes on a valid/ready port.
// It is used as an on-chip loopback monitor and as the command decoder front end when the link feeds another ICE40.
// All SPI pins are oversampled on clk; the SPI clock runs at clk/4 or slower (clk/8 nominal).
// PARAMETERS
// DATA_W       8  bits per word, shifted MSB first
// SYNC_STAGES  2  synchroniser flops on each SPI input (minimum 2)
// COUNT_W      8  width of the per-frame byte counter
// PORTS
// clk           in   1        system clock; all logic on posedge
// reset         in   1        synchronous, active-high
// enable        in   1        1 = receiver armed; 0 = ignore bus
// spi_cs_n      in   1        chip select, active low (async to clk)
// spi_sclk      in   1        SPI clock, idle low (async to clk)
// spi_mosi      in   1        serial data; sampled on sclk rising edge
// rx_data       out  DATA_W   received word, held while rx_valid=1
// rx_valid      out  1        word available; held until rx_ready=1
// rx_ready      in   1        consumer accepts word when rx_valid && rx_ready
// rx_first      out  1        rx_data is the first word of its CS frame (qualified by rx_valid)
// rx_overrun    out  1        1-cycle pulse: new word arrived while rx_valid && !rx_ready
// frame_active  out  1        1 while in ACTIVE
// byte_count    out  COUNT_W  words completed in current/last frame; saturates at all-ones
// frame_done    out  1        1-cycle pulse: CS rose on a word boundary after >=1 word
// frame_error   out  1        1-cycle pulse: CS rose or enable dropped mid-word
// BEHAVIOUR
// - Reset values: sync chains cs=1, sclk=0, mosi=0; all outputs 0; FSM=WAIT_HIGH; bit_cnt=0.
// - Edge detect on synced signals only: sclk_rise = s_sclk & ~s_sclk_d; cs_fall/cs_rise likewise. mosi delayed by the same stages.
// - FSM WAIT_HIGH: go to IDLE when s_cs_n=1. This is the state after reset; a frame already in progress is never joined.
// - FSM IDLE: on cs_fall && enable go to ACTIVE, clear bit_cnt, byte_count and the first flag.
// - FSM ACTIVE, each sclk_rise: shift <= {shift[DATA_W-2:0], s_mosi}; bit_cnt++.
//   - On the DATA_W-th bit: next cycle rx_data <= word, rx_valid=1, rx_first=first flag, byte_count++ (saturating), bit_cnt=0.
// - Latency: rx_valid rises SYNC_STAGES+2 clk after the physical 8th sclk rise.
// - Handshake: rx_valid drops the cycle after rx_valid&&rx_ready. Completion and acceptance in the same cycle: the new word wins and rx_valid stays 1.
// - Overrun: a word completes while rx_valid && !rx_ready. rx_data is overwritten, rx_overrun pulses 1 cycle, rx_valid stays 1.
// - Simultaneous sclk_rise and cs_rise in one cycle: the bit is taken first, then the CS rule below is evaluated.
// - cs_rise in ACTIVE: go to IDLE.
//   - bit_cnt==0 and byte_count>0: frame_done pulse.
//   - bit_cnt!=0: frame_error pulse, partial bits discarded, no rx_valid.
//   - byte_count is held until the next cs_fall.
// - enable=0 in ACTIVE: go to WAIT_HIGH on the next cycle. frame_error pulses if bit_cnt!=0; no frame_done.
// - enable=0 in IDLE: cs_fall is ignored.
// - A pending rx_valid word survives the end of its frame.
// - Reset mid-frame: every output cleared in the cycle after reset, including a pending rx_valid. The rest of that frame is ignored (WAIT_HIGH).
// - sclk edges while cs high or outside ACTIVE: ignored; the shift register is untouched.
// - byte_count at all-ones: stays all-ones; words are still delivered.
// TESTING
// 1. Reset, enable=1, frame 0xA5 at sclk=clk/8, rx_ready=1
//    -> one rx_valid with rx_data=0xA5, rx_first=1; frame_done pulse; byte_count=1.
// 2. One CS frame 0x2A,0x00,0xFF, rx_ready=1
//    -> three rx_valid in order; rx_first only on 0x2A; byte_count=3; one frame_done.
// 3. rx_ready=0, frame 0x11,0x22
//    -> rx_data=0x22, rx_valid=1, one rx_overrun pulse; raise rx_ready -> rx_valid drops next cycle.
// 4. CS raised after 5 bits of 0xC3
//    -> frame_error pulse, no rx_valid, no frame_done. Next full frame 0x3C is received correctly.
// 5. Reset asserted after 3 bits; CS stays low, 13 more bits sent
//    -> no rx_valid. After CS high, a new frame 0x7E is received and rx_first=1.
// 6. enable=0, frame 0x55
//    -> no outputs. enable dropped after 4 bits of a frame -> frame_error pulse, FSM to WAIT_HIGH.

Source files
------------

// File: rtl/tft_spi_byte_receiver.sv
// ============================================================================
// Module  : tft_spi_byte_receiver
// Purpose : SPI mode-0 slave receiver that oversamples cs/sclk/mosi on clk
//           and delivers whole words on a valid/ready port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tft_spi_byte_receiver #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               spi_cs_n,
  input  logic               spi_sclk,
  input  logic               spi_mosi,
  output logic [DATA_W-1:0]  rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               rx_first,
  output logic               rx_overrun,
  output logic               frame_active,
  output logic [COUNT_W-1:0] byte_count,
  output logic               frame_done,
  output logic               frame_error
);

  localparam int BIT_W    = $clog2(DATA_W + 1);
  localparam int SETTLE   = SYNC_STAGES + 1;
  localparam int SETTLE_W = $clog2(SETTLE + 1);
  localparam logic [BIT_W-1:0]    LAST_BIT  = BIT_W'(DATA_W);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE);

  typedef enum logic [1:0] {
    ST_WAIT_HIGH = 2'd0,
    ST_IDLE      = 2'd1,
    ST_ACTIVE    = 2'd2
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   cs_n_dly_q, sclk_dly_q;
  logic [SETTLE_W-1:0]    settle_q;
  logic [DATA_W-1:0]      shift_q, word_q, rx_data_q;
  logic [BIT_W-1:0]       bit_cnt_q;
  logic                   first_q, word_first_q, word_done_q;
  logic                   rx_valid_q, rx_first_q, rx_overrun_q;
  logic                   frame_active_q, frame_done_q, frame_error_q;
  logic [COUNT_W-1:0]     byte_count_q;

  logic                   s_cs_n, s_sclk, s_mosi;
  logic                   sclk_rise, cs_fall, cs_rise;
  logic                   take_bit, word_cmp;
  logic [DATA_W-1:0]      shift_d;
  logic [BIT_W-1:0]       bit_cnt_d, bit_cnt_inc;

  assign s_cs_n    = cs_sync_q[SYNC_STAGES-1];
  assign s_sclk    = sclk_sync_q[SYNC_STAGES-1];
  assign s_mosi    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = s_sclk & ~sclk_dly_q;
  assign cs_fall   = ~s_cs_n & cs_n_dly_q;
  assign cs_rise   = s_cs_n & ~cs_n_dly_q;

  always_comb begin
    take_bit    = (state_q == ST_ACTIVE) && enable && sclk_rise;
    bit_cnt_inc = bit_cnt_q + 1'b1;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    word_cmp    = 1'b0;
    if (take_bit) begin
      shift_d   = {shift_q[DATA_W-2:0], s_mosi};
      word_cmp  = (bit_cnt_inc == LAST_BIT);
      bit_cnt_d = word_cmp ? '0 : bit_cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_WAIT_HIGH;
      cs_sync_q      <= '1;
      sclk_sync_q    <= '0;
      mosi_sync_q    <= '0;
      cs_n_dly_q     <= 1'b1;
      sclk_dly_q     <= 1'b0;
      settle_q       <= '0;
      shift_q        <= '0;
      word_q         <= '0;
      bit_cnt_q      <= '0;
      first_q        <= 1'b0;
      word_first_q   <= 1'b0;
      word_done_q    <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_first_q     <= 1'b0;
      rx_overrun_q   <= 1'b0;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_error_q  <= 1'b0;
      byte_count_q   <= '0;
    end else begin
      cs_sync_q     <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q   <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_n_dly_q    <= s_cs_n;
      sclk_dly_q    <= s_sclk;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
      word_done_q   <= word_cmp;

      if (word_cmp) begin
        word_q       <= shift_d;
        word_first_q <= first_q;
        first_q      <= 1'b0;
      end

      // A freshly completed word always wins over a same-cycle acceptance.
      if (word_done_q) begin
        rx_data_q    <= word_q;
        rx_valid_q   <= 1'b1;
        rx_first_q   <= word_first_q;
        rx_overrun_q <= rx_valid_q && !rx_ready;
        if (byte_count_q != '1) byte_count_q <= byte_count_q + 1'b1;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        ST_WAIT_HIGH: begin
          frame_active_q <= 1'b0;
          // Let the synchronisers flush so a frame in progress is never joined.
          if (settle_q != SETTLE_MAX) settle_q <= settle_q + 1'b1;
          else if (s_cs_n && cs_n_dly_q) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (cs_fall && enable) begin
            state_q        <= ST_ACTIVE;
            frame_active_q <= 1'b1;
            bit_cnt_q      <= '0;
            byte_count_q   <= '0;
            first_q        <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (!enable) begin
            state_q        <= ST_WAIT_HIGH;
            settle_q       <= '0;
            frame_active_q <= 1'b0;
            frame_error_q  <= (bit_cnt_q != '0);
            bit_cnt_q      <= '0;
          end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            if (cs_rise) begin
              state_q        <= ST_IDLE;
              frame_active_q <= 1'b0;
              bit_cnt_q      <= '0;
              if (bit_cnt_d != '0) frame_error_q <= 1'b1;
              else frame_done_q <= (byte_count_q != '0) || word_done_q || word_cmp;
            end
          end
        end
        default: begin
          state_q        <= ST_WAIT_HIGH;
          settle_q       <= '0;
          frame_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_first     = rx_first_q;
  assign rx_overrun   = rx_overrun_q;
  assign frame_active = frame_active_q;
  assign byte_count   = byte_count_q;
  assign frame_done   = frame_done_q;
  assign frame_error  = frame_error_q;

endmodule

`default_nettype wire
